multi_phase_signal_controller: RTL

Parametrised successor to the two-road intersection controller. It sequences green → yellow → all-red clearance across `NUM_PHASES` approaches, latches pedestrian requests synchronously, and shortens green to serve waiting requests. It also provides flashing-yellow and flashing-red (error) modes. It sits between the board's debounced switch/button inputs and the lamp drivers, one 3-bit lamp group per approach.

---
 rtl/multi_phase_signal_controller_if.sv | 24 ++
 rtl/multi_phase_signal_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_signal_controller_if.sv
// Interface bundle for multi_phase_signal_controller: switch/button inputs
// and lamp-driver outputs. master = board side, slave = controller side.
interface multi_phase_signal_controller_if #(
  parameter int unsigned NUM_PHASES = 4
);
  localparam int unsigned PW = $clog2(NUM_PHASES);

  logic [NUM_PHASES-1:0]   ped_req;
  logic                    error;
  logic                    flash_mode;
  logic [3*NUM_PHASES-1:0] lights;
  logic [PW-1:0]           active_phase;
  logic [NUM_PHASES-1:0]   ped_pending;

  modport master (
    output ped_req, error, flash_mode,
    input  lights, active_phase, ped_pending
  );

  modport slave (
    input  ped_req, error, flash_mode,
    output lights, active_phase, ped_pending
  );
endinterface

// File: rtl/multi_phase_signal_controller.sv
// Multi-approach traffic signal sequencer with pedestrian-request skipping and
// flashing modes. Define TL_ALL_RED_EN to compile in the all-red clearance state.
module multi_phase_signal_controller #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned INIT_T     = 100_000_000,
  parameter int unsigned GREEN_MIN  = 250_000_000,
  parameter int unsigned GREEN_MAX  = 750_000_000,
  parameter int unsigned YELLOW_T   = 100_000_000,
  parameter int unsigned ALL_RED_T  = 50_000_000,
  parameter int unsigned FLASH_T    = 50_000_000
) (
  input logic                            clk,
  input logic                            reset,
  multi_phase_signal_controller_if.slave bus
);

  localparam int unsigned PW = $clog2(NUM_PHASES);

  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_T - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_GREEN, ST_YELLOW, ST_ALL_RED, ST_FLASH_Y, ST_FLASH_R
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [NUM_PHASES-1:0]   pend_q, pend_d;
  logic                    lit_q, lit_d;

  logic [NUM_PHASES-1:0]   phase_onehot;
  logic [NUM_PHASES-1:0]   req_accept;
  logic                    other_pending;
  logic [PW-1:0]           next_phase;
  logic                    enter_green;
  logic [PW-1:0]           green_phase;
  logic [2:0]              grp;
  logic [3*NUM_PHASES-1:0] lamps;

`ifdef TL_ALL_RED_EN
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED_T - 1);
  // Set when ALL_RED was entered from a flashing mode, so green restarts at phase 0.
  logic restart_q, restart_d;
`else
  logic unused_all_red_t;
  assign unused_all_red_t = ^ALL_RED_T;
`endif

  assign phase_onehot  = NUM_PHASES'(1) << phase_q;
  assign other_pending = |(pend_q & ~phase_onehot);
  assign req_accept    = bus.ped_req & ~((state_q == ST_GREEN) ? phase_onehot : '0);

  // First pending approach after the active one (wrapping, self last), else plain +1.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found      = 1'b0;
    idx        = '0;
    next_phase = PW'((32'(phase_q) + 1) % NUM_PHASES);
    if (|pend_q) begin
      for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
        idx = PW'((32'(phase_q) + k) % NUM_PHASES);
        if (!found && pend_q[idx]) begin
          next_phase = idx;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    phase_d     = phase_q;
    lit_d       = lit_q;
    pend_d      = pend_q | req_accept;
    enter_green = 1'b0;
    green_phase = next_phase;
`ifdef TL_ALL_RED_EN
    restart_d   = restart_q;
`endif
    if (bus.error) begin
      if (state_q != ST_FLASH_R) begin
        state_d = ST_FLASH_R;
        cnt_d   = '0;
        lit_d   = 1'b1;
      end else if (cnt_q == FLASH_LAST) begin
        cnt_d = '0;
        lit_d = ~lit_q;
      end
    end else if (bus.flash_mode) begin
      if (state_q != ST_FLASH_Y) begin
        state_d = ST_FLASH_Y;
        cnt_d   = '0;
        lit_d   = 1'b1;
      end else if (cnt_q == FLASH_LAST) begin
        cnt_d = '0;
        lit_d = ~lit_q;
      end
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == INIT_LAST) begin
            enter_green = 1'b1;
            green_phase = '0;
          end
        end
        ST_GREEN: begin
          if (cnt_q == GMAX_LAST || (cnt_q >= GMIN_LAST && other_pending)) begin
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
`ifdef TL_ALL_RED_EN
            state_d   = ST_ALL_RED;
            cnt_d     = '0;
            restart_d = 1'b0;
`else
            enter_green = 1'b1;
`endif
          end
        end
`ifdef TL_ALL_RED_EN
        ST_ALL_RED: begin
          if (cnt_q == AR_LAST) begin
            enter_green = 1'b1;
            if (restart_q) green_phase = '0;
          end
        end
`endif
        ST_FLASH_Y, ST_FLASH_R: begin
`ifdef TL_ALL_RED_EN
          state_d   = ST_ALL_RED;
          cnt_d     = '0;
          phase_d   = '0;
          restart_d = 1'b1;
`else
          enter_green = 1'b1;
          green_phase = '0;
`endif
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
    // A request arriving on the entry cycle is dropped: that approach is being served.
    if (enter_green) begin
      state_d             = ST_GREEN;
      cnt_d               = '0;
      phase_d             = green_phase;
      pend_d[green_phase] = 1'b0;
`ifdef TL_ALL_RED_EN
      restart_d           = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      phase_q   <= '0;
      pend_q    <= '0;
      lit_q     <= 1'b1;
`ifdef TL_ALL_RED_EN
      restart_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      lit_q     <= lit_d;
`ifdef TL_ALL_RED_EN
      restart_q <= restart_d;
`endif
    end
  end

  always_comb begin
    lamps = '0;
    grp   = 3'b100;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      grp = 3'b100;
      case (state_q)
        ST_GREEN:   if (PW'(i) == phase_q) grp = 3'b001;
        ST_YELLOW:  if (PW'(i) == phase_q) grp = 3'b010;
        ST_FLASH_R: grp = lit_q ? 3'b100 : 3'b000;
        ST_FLASH_Y: grp = lit_q ? 3'b010 : 3'b000;
        default:    grp = 3'b100;
      endcase
      lamps[3*i +: 3] = grp;
    end
  end

  assign bus.lights       = lamps;
  assign bus.active_phase = phase_q;
  assign bus.ped_pending  = pend_q;

endmodule
